// File: rtl/grey_seq_pkg.sv
// Shared types and constants for the Gray-coded three-digit display sequencer:
// state encoding, seven-segment table and the segment lookup helper.
package grey_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_100 = 3'd1,
    GAP_100  = 3'd2,
    SHOW_010 = 3'd3,
    GAP_010  = 3'd4,
    SHOW_001 = 3'd5,
    GAP_001  = 3'd6
  } seq_state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam int         DP_BIT    = 7;

  // Entries 10..15 are padded with the E pattern so a 4-bit index is always in range
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_E, SEG_E, SEG_E, SEG_E, SEG_E, SEG_E,
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] digit_seg(input logic [4:0] bin);
    if (bin[4]) begin
      return SEG_E;
    end else begin
      return SEG_TABLE[bin[3:0]];
    end
  endfunction

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/grey_decode.sv
// Gray-to-binary conversion of one 5-bit digit, flagging values above 9 as invalid.
module grey_decode
(
  input  logic [4:0] i_gray,
  output logic [4:0] o_bin,
  output logic       o_valid
);

  assign o_bin[4] = i_gray[4];
  assign o_bin[3] = ^i_gray[4:3];
  assign o_bin[2] = ^i_gray[4:2];
  assign o_bin[1] = ^i_gray[4:1];
  assign o_bin[0] = ^i_gray[4:0];
  assign o_valid  = (o_bin < 5'd10);

endmodule

// File: rtl/grey_digit_sequencer.sv
// Shows three latched Gray-coded digits in turn on a seven-segment output with blank gaps.
// Optional leading-zero blanking is enabled by defining GREY_SEQ_LZB_EN.
module grey_digit_sequencer
  import grey_seq_pkg::*;
#(
  parameter int pDWELL = 1000,
  parameter int pGAP   = 250
)
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [4:0] i_100,
  input  logic [4:0] i_010,
  input  logic [4:0] i_001,
  output logic [7:0] o_seg,
  output logic       o_busy,
  output logic       o_err
);

  localparam int                CNT_W    = $clog2(max_int(pDWELL, pGAP) + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(pDWELL - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(pGAP - 1);
  localparam logic [7:0]        DP_MASK  = 8'd1 << DP_BIT;

  seq_state_t       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [7:0]       seg_100_r, seg_010_r, seg_001_r;
  logic [7:0]       pat_100_s, pat_010_s, pat_001_s;
  logic [7:0]       seg_nx_s;
  logic             load_acc_s;
  logic [4:0]       bin_100_s, bin_010_s, bin_001_s;
  logic             valid_100_s, valid_010_s, valid_001_s;

  grey_decode u_dec_100 (.i_gray(i_100), .o_bin(bin_100_s), .o_valid(valid_100_s));
  grey_decode u_dec_010 (.i_gray(i_010), .o_bin(bin_010_s), .o_valid(valid_010_s));
  grey_decode u_dec_001 (.i_gray(i_001), .o_bin(bin_001_s), .o_valid(valid_001_s));

  // Segment patterns for the live digit inputs, captured on an accepted load
  always_comb begin
    pat_001_s = digit_seg(bin_001_s);
`ifdef GREY_SEQ_LZB_EN
    if (bin_100_s == 5'd0) begin
      pat_100_s = SEG_BLANK;
      if (bin_010_s == 5'd0) begin
        pat_010_s = SEG_BLANK;
      end else begin
        pat_010_s = digit_seg(bin_010_s);
      end
    end else begin
      pat_100_s = digit_seg(bin_100_s);
      pat_010_s = digit_seg(bin_010_s);
    end
`else
    pat_100_s = digit_seg(bin_100_s);
    pat_010_s = digit_seg(bin_010_s);
`endif
  end

  // Next state, dwell counter and next output pattern
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    load_acc_s = 1'b0;
    seg_nx_s   = SEG_BLANK;
    case (state_r)
      IDLE: begin
        if (i_load) begin
          state_nx_s = SHOW_100;
          cnt_nx_s   = DWELL_LD;
          load_acc_s = 1'b1;
        end else begin
          cnt_nx_s   = CNT_ZERO;
        end
      end
      SHOW_100, SHOW_010, SHOW_001, GAP_100, GAP_010, GAP_001: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end else if (state_r == GAP_001) begin
          state_nx_s = IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = seq_state_t'(state_r + 3'd1);
          if (state_r == GAP_100 || state_r == GAP_010) begin
            cnt_nx_s = DWELL_LD;
          end else begin
            cnt_nx_s = GAP_LD;
          end
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase

    // Outputs are registered from the next state so the first digit appears on the accepting edge
    case (state_nx_s)
      SHOW_100: begin
        if (load_acc_s) begin
          seg_nx_s = pat_100_s | DP_MASK;
        end else begin
          seg_nx_s = seg_100_r | DP_MASK;
        end
      end
      SHOW_010: seg_nx_s = seg_010_r;
      SHOW_001: seg_nx_s = seg_001_r;
      default:  seg_nx_s = SEG_BLANK;
    endcase
  end

  // State, counter, latched digits and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      seg_100_r <= SEG_BLANK;
      seg_010_r <= SEG_BLANK;
      seg_001_r <= SEG_BLANK;
      o_seg     <= SEG_BLANK;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      o_seg   <= seg_nx_s;
      o_busy  <= (state_nx_s != IDLE);
      if (load_acc_s) begin
        seg_100_r <= pat_100_s;
        seg_010_r <= pat_010_s;
        seg_001_r <= pat_001_s;
        o_err     <= ~(valid_100_s & valid_010_s & valid_001_s);
      end
    end
  end

endmodule
